// File: rtl/memory_access_unit.sv
// rtl/memory_access_unit.sv - memory stage serialising byte/vector loads and stores onto an 8-bit req/ready port
// Optional macro MEM_ALIGN_CHECK_EN: misaligned vector ops skip the bus and pulse misalign_err.
module memory_access_unit #(
    parameter int ADDR_W    = 16,
    parameter int VEC_BYTES = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   mem_read_memory,
    input  logic                   mem_write_memory,
    input  logic                   vector_mem_read_memory,
    input  logic                   vector_mem_write_memory,
    input  logic [ADDR_W-1:0]      address_memory,
    input  logic [15:0]            store_data_memory,
    input  logic [8*VEC_BYTES-1:0] store_vector_memory,
    output logic                   stall_memory,
    output logic [7:0]             data_from_memory_out,
    output logic [8*VEC_BYTES-1:0] vector_data_from_memory_out,
    output logic                   dmem_req,
    output logic                   dmem_we,
    output logic [ADDR_W-1:0]      dmem_addr,
    output logic [7:0]             dmem_wdata,
    input  logic [7:0]             dmem_rdata,
    input  logic                   dmem_ready,
    output logic                   misalign_err
);

    localparam int VEC_W = 8 * VEC_BYTES;
    localparam int IDX_W = (VEC_BYTES > 1) ? $clog2(VEC_BYTES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t             r_state, w_next;
    logic               r_vec, r_we;
    logic [ADDR_W-1:0]  r_base;
    logic [7:0]         r_sdata;
    logic [VEC_W-1:0]   r_svec, r_buf, r_vec_out;
    logic [7:0]         r_data_out;
    logic [IDX_W-1:0]   r_idx;
`ifdef MEM_ALIGN_CHECK_EN
    logic               r_misalign;
`endif

    logic               w_any, w_vec, w_we, w_misaligned, w_last;
    logic [VEC_W-1:0]   w_buf_next;
    logic               w_unused_sdata_hi;

    assign w_unused_sdata_hi = &{1'b0, store_data_memory[15:8]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_any = mem_read_memory | mem_write_memory | vector_mem_read_memory | vector_mem_write_memory;
        w_vec = vector_mem_write_memory | vector_mem_read_memory;
        // Priority vector_write > vector_read > write > read collapses to this write-enable.
        w_we  = vector_mem_write_memory | (~vector_mem_read_memory & mem_write_memory);
`ifdef MEM_ALIGN_CHECK_EN
        w_misaligned = w_vec && (address_memory[3:0] != 4'd0);
`else
        w_misaligned = 1'b0;
`endif
        w_last     = !r_vec || (r_idx == IDX_W'(VEC_BYTES - 1));
        w_buf_next = r_buf;
        w_buf_next[{r_idx, 3'b000} +: 8] = dmem_rdata;

        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_any) w_next = w_misaligned ? S_DONE : S_BUSY;
            S_BUSY: if (dmem_ready && w_last) w_next = S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase

        stall_memory = !reset && ((r_state == S_IDLE && w_any) || r_state == S_BUSY);
        dmem_req     = (r_state == S_BUSY);
        dmem_we      = dmem_req && r_we;
        dmem_addr    = dmem_req ? (r_base + ADDR_W'(r_idx)) : '0;
        dmem_wdata   = 8'h00;
        if (dmem_we) dmem_wdata = r_vec ? r_svec[{r_idx, 3'b000} +: 8] : r_sdata;
        data_from_memory_out        = r_data_out;
        vector_data_from_memory_out = r_vec_out;
`ifdef MEM_ALIGN_CHECK_EN
        misalign_err = r_misalign && (r_state == S_DONE);
`else
        misalign_err = 1'b0;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vec      <= 1'b0;
            r_we       <= 1'b0;
            r_base     <= '0;
            r_sdata    <= '0;
            r_svec     <= '0;
            r_buf      <= '0;
            r_idx      <= '0;
            r_data_out <= '0;
            r_vec_out  <= '0;
`ifdef MEM_ALIGN_CHECK_EN
            r_misalign <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: if (w_any) begin
                    r_vec   <= w_vec;
                    r_we    <= w_we;
                    r_base  <= address_memory;
                    r_sdata <= store_data_memory[7:0];
                    r_svec  <= store_vector_memory;
                    r_idx   <= '0;
`ifdef MEM_ALIGN_CHECK_EN
                    if (w_misaligned) begin
                        r_misalign <= 1'b1;
                        if (!w_we) r_vec_out <= '0;
                    end
`endif
                end
                S_BUSY: if (dmem_ready) begin
                    r_buf <= w_buf_next;
                    r_idx <= r_idx + 1'b1;
                    // Results publish only on the final beat of a load, i.e. on entry to DONE.
                    if (w_last && !r_we) begin
                        if (r_vec) r_vec_out  <= w_buf_next;
                        else       r_data_out <= dmem_rdata;
                    end
                end
                S_DONE: begin
`ifdef MEM_ALIGN_CHECK_EN
                    r_misalign <= 1'b0;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_access_unit.sv
// tb/tb_memory_access_unit.sv - scoreboard bench for memory_access_unit (honours MEM_ALIGN_CHECK_EN)
module tb_memory_access_unit;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  wdata;
    } beat_t;

`ifdef MEM_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic         rd, wr, vrd, vwr, ready;
    logic [15:0]  addr, sdata;
    logic [127:0] svec;
    logic         stall, req, we, misalign;
    logic [7:0]   dout, wdata, rdata;
    logic [127:0] vout;
    logic [15:0]  daddr;

    logic [7:0]   mem [0:65535];
    assign rdata = mem[daddr];

    beat_t        q[$];
    int           n_tests = 0, n_fail = 0, n_beats = 0;
    logic [7:0]   exp_data = 8'h00;
    logic [127:0] exp_vec = '0;

    memory_access_unit dut (
        .clk(clk), .reset(reset),
        .mem_read_memory(rd), .mem_write_memory(wr),
        .vector_mem_read_memory(vrd), .vector_mem_write_memory(vwr),
        .address_memory(addr), .store_data_memory(sdata), .store_vector_memory(svec),
        .stall_memory(stall), .data_from_memory_out(dout), .vector_data_from_memory_out(vout),
        .dmem_req(req), .dmem_we(we), .dmem_addr(daddr), .dmem_wdata(wdata),
        .dmem_rdata(rdata), .dmem_ready(ready), .misalign_err(misalign)
    );

    // Beat monitor: pops the scoreboard on every completed beat and checks held beats stay stable.
    logic        held_valid = 1'b0;
    logic [16:0] held;
    always @(negedge clk) begin
        #2;
        if (reset || !req) begin
            held_valid = 1'b0;
        end else begin
            if (held_valid) begin
                n_tests++;
                if ({we, daddr} !== held) begin
                    n_fail++;
                    $display("FAIL beat_hold: got %h required %h", {we, daddr}, held);
                end
            end
            if (ready) begin
                beat_t e;
                n_beats++;
                n_tests++;
                held_valid = 1'b0;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL beat_unexpected: got we=%b addr=%h", we, daddr);
                end else begin
                    e = q.pop_front();
                    if (we !== e.we || daddr !== e.addr || (e.we && wdata !== e.wdata)) begin
                        n_fail++;
                        $display("FAIL beat: got we=%b addr=%h wdata=%h required we=%b addr=%h wdata=%h",
                                 we, daddr, wdata, e.we, e.addr, e.wdata);
                    end
                end
                if (we) mem[daddr] = wdata;
            end else begin
                held_valid = 1'b1;
                held = {we, daddr};
            end
        end
    end

    task automatic set_flags(input logic [3:0] f);
        {vwr, vrd, wr, rd} = f;
    endtask

    task automatic clear_flags();
        set_flags(4'b0000);
        ready = 1'b1;
        @(negedge clk);
    endtask

    // Drives one op from a negedge and returns at negedge+1 of the first non-stall (DONE) cycle.
    task automatic do_op(input logic [3:0] f, input logic [15:0] a, input logic [15:0] sd,
                         input logic [127:0] sv, input bit toggle,
                         output int stall_cyc, output int busy_cyc);
        bit vec, wr_op, done;
        int n;
        vec   = f[3] | f[2];
        wr_op = f[3] | (!f[2] & f[1]);
        n     = vec ? 16 : 1;
        if (f != 4'b0000 && !(ALIGN && vec && a[3:0] != 4'd0))
            for (int k = 0; k < n; k++)
                q.push_back('{wr_op, a + 16'(k), vec ? sv[8*k +: 8] : sd[7:0]});
        set_flags(f);
        addr = a; sdata = sd; svec = sv; ready = 1'b1;
        stall_cyc = 0; busy_cyc = 0; done = 1'b0;
        for (int t = 0; t < 300 && !done; t++) begin
            #1;
            if (!stall) done = 1'b1;
            else begin
                stall_cyc++;
                if (req) busy_cyc++;
                @(negedge clk);
                if (toggle) ready = !ready;
            end
        end
        if (!done) stall_cyc = -1;
    endtask

    task automatic test_reset();
        reset = 1'b1; set_flags(4'b0001); addr = 16'h0010; sdata = '0; svec = '0; ready = 1'b1;
        @(negedge clk); #1;
        n_tests++;
        if (stall !== 1'b0 || req !== 1'b0) begin
            n_fail++; $display("FAIL reset_stall_req: got stall=%b req=%b required 0 0", stall, req);
        end
        n_tests++;
        if ({dout, vout, we, daddr, wdata, misalign} !== '0) begin
            n_fail++; $display("FAIL reset_outputs: got dout=%h vout=%h required 0", dout, vout);
        end
        set_flags(4'b0000);
        @(negedge clk); reset = 1'b0;
        @(negedge clk); #1;
        n_tests++;
        if (stall !== 1'b0 || req !== 1'b0) begin
            n_fail++; $display("FAIL idle_after_reset: got stall=%b req=%b required 0 0", stall, req);
        end
        @(negedge clk);
    endtask

    task automatic test_scalar_load();
        int s, b;
        mem[16'h0010] = 8'hA5;
        do_op(4'b0001, 16'h0010, 16'h0000, '0, 1'b0, s, b);
        exp_data = 8'hA5;
        n_tests++;
        if (s !== 2 || b !== 1) begin
            n_fail++; $display("FAIL scalar_load_latency: got stall=%0d busy=%0d required 2 1", s, b);
        end
        n_tests++;
        if (dout !== exp_data || vout !== exp_vec) begin
            n_fail++; $display("FAIL scalar_load_data: got %h required %h", dout, exp_data);
        end
        clear_flags();
    endtask

    task automatic test_scalar_store();
        int s, b;
        do_op(4'b0010, 16'hFFFF, 16'h1234, '0, 1'b0, s, b);
        n_tests++;
        if (s !== 2 || dout !== exp_data || vout !== exp_vec || mem[16'hFFFF] !== 8'h34) begin
            n_fail++; $display("FAIL scalar_store: got stall=%0d dout=%h mem=%h required 2 %h 34",
                               s, dout, mem[16'hFFFF], exp_data);
        end
        clear_flags();
    endtask

    task automatic test_vector_store();
        int s, b, nb0;
        logic [127:0] v;
        for (int k = 0; k < 16; k++) v[8*k +: 8] = 8'(k);
        nb0 = n_beats;
        do_op(4'b1000, 16'h0020, 16'h0000, v, 1'b0, s, b);
        n_tests++;
        if (s !== 17 || b !== 16 || n_beats - nb0 !== 16) begin
            n_fail++; $display("FAIL vector_store_latency: got stall=%0d busy=%0d beats=%0d required 17 16 16",
                               s, b, n_beats - nb0);
        end
        n_tests++;
        if (dout !== exp_data || vout !== exp_vec) begin
            n_fail++; $display("FAIL vector_store_outputs: got %h %h required %h %h", dout, vout, exp_data, exp_vec);
        end
        n_tests++;
        if (mem[16'h0020] !== 8'h00 || mem[16'h002F] !== 8'h0F) begin
            n_fail++; $display("FAIL vector_store_mem: got %h %h required 00 0f", mem[16'h0020], mem[16'h002F]);
        end
        clear_flags();
    endtask

    task automatic test_vector_load_wrap();
        int s, b;
        for (int k = 0; k < 16; k++) begin
            mem[16'hFFF0 + 16'(k)] = 8'($urandom);
            exp_vec[8*k +: 8] = mem[16'hFFF0 + 16'(k)];
        end
        do_op(4'b0100, 16'hFFF0, 16'h0000, '0, 1'b1, s, b);
        n_tests++;
        if (s !== 33 || b !== 32) begin
            n_fail++; $display("FAIL vector_load_toggle_latency: got stall=%0d busy=%0d required 33 32", s, b);
        end
        n_tests++;
        if (vout !== exp_vec || dout !== exp_data) begin
            n_fail++; $display("FAIL vector_load_data: got %h required %h", vout, exp_vec);
        end
        clear_flags();
    endtask

    task automatic test_reset_mid_access();
        int s, b;
        for (int k = 0; k < 16; k++) q.push_back('{1'b0, 16'h0100 + 16'(k), 8'h00});
        set_flags(4'b0100); addr = 16'h0100; ready = 1'b1;
        repeat (6) @(negedge clk);
        #1;
        n_tests++;
        if (req !== 1'b1 || daddr !== 16'h0105) begin
            n_fail++; $display("FAIL mid_reset_beat5: got req=%b addr=%h required 1 0105", req, daddr);
        end
        reset = 1'b1;
        #2;
        n_tests++;
        if ({req, stall, dout, vout, we, daddr, wdata, misalign} !== '0) begin
            n_fail++; $display("FAIL mid_reset_outputs: got req=%b stall=%b vout=%h required all 0", req, stall, vout);
        end
        q.delete();
        exp_data = 8'h00; exp_vec = '0;
        set_flags(4'b0000);
        @(negedge clk); reset = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 16; k++) exp_vec[8*k +: 8] = mem[16'h0100 + 16'(k)];
        do_op(4'b0100, 16'h0100, 16'h0000, '0, 1'b0, s, b);
        n_tests++;
        if (s !== 17 || vout !== exp_vec) begin
            n_fail++; $display("FAIL restart_after_reset: got stall=%0d vout=%h required 17 %h", s, vout, exp_vec);
        end
        clear_flags();
    endtask

    task automatic test_priority_back_to_back();
        int s, b, nb0;
        logic [127:0] v;
        logic         ok;
        v = {$urandom, $urandom, $urandom, $urandom};
        nb0 = n_beats;
        do_op(4'b1111, 16'h0040, 16'hBEEF, v, 1'b0, s, b);
        n_tests++;
        if (s !== 17 || b !== 16 || n_beats - nb0 !== 16) begin
            n_fail++; $display("FAIL priority_latency: got stall=%0d busy=%0d beats=%0d required 17 16 16",
                               s, b, n_beats - nb0);
        end
        ok = 1'b1;
        for (int k = 0; k < 16; k++) if (mem[16'h0040 + 16'(k)] !== v[8*k +: 8]) ok = 1'b0;
        n_tests++;
        if (!ok || dout !== exp_data || vout !== exp_vec) begin
            n_fail++; $display("FAIL priority_store_effect: got ok=%b dout=%h required 1 %h", ok, dout, exp_data);
        end
        @(negedge clk); #1;
        n_tests++;
        if (req !== 1'b0 || stall !== 1'b1) begin
            n_fail++; $display("FAIL done_retrigger: got req=%b stall=%b required 0 1", req, stall);
        end
        set_flags(4'b0000);
        @(negedge clk); #1;
        n_tests++;
        if (req !== 1'b0 || stall !== 1'b0 || q.size() != 0) begin
            n_fail++; $display("FAIL after_done_idle: got req=%b stall=%b queued=%0d required 0 0 0", req, stall, q.size());
        end
        @(negedge clk);
    endtask

    task automatic test_misaligned();
        int s, b;
        if (ALIGN) exp_vec = '0;
        else for (int k = 0; k < 16; k++) exp_vec[8*k +: 8] = mem[16'h0023 + 16'(k)];
        do_op(4'b0100, 16'h0023, 16'h0000, '0, 1'b0, s, b);
        n_tests++;
        if (s !== (ALIGN ? 1 : 17) || b !== (ALIGN ? 0 : 16)) begin
            n_fail++; $display("FAIL misalign_latency: got stall=%0d busy=%0d required %0d %0d",
                               s, b, ALIGN ? 1 : 17, ALIGN ? 0 : 16);
        end
        n_tests++;
        if (misalign !== ALIGN || vout !== exp_vec) begin
            n_fail++; $display("FAIL misalign_result: got err=%b vout=%h required %b %h", misalign, vout, ALIGN, exp_vec);
        end
        clear_flags(); #1;
        n_tests++;
        if (misalign !== 1'b0) begin
            n_fail++; $display("FAIL misalign_pulse: got %b required 0", misalign);
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'(i * 7 + 3) ^ 8'(i >> 8);
        test_reset();
        test_scalar_load();
        test_scalar_store();
        test_vector_store();
        test_vector_load_wrap();
        test_reset_mid_access();
        test_priority_back_to_back();
        test_misaligned();
        n_tests++;
        if (q.size() != 0) begin
            n_fail++; $display("FAIL scoreboard_drain: got %0d beats pending required 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
